// File: rtl/clock_pkg.sv
// Shared types and digit indices for the front-panel time-set logic.
// Pure declarations; no timing of its own.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_IDLE = 2'd1,
        PULSE    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam int SEC_U      = 0;
    localparam int SEC_T      = 1;
    localparam int MIN_U      = 2;
    localparam int MIN_T      = 3;
    localparam int HR_U       = 4;
    localparam int HR_T       = 5;
    localparam int NUM_DIGITS = 6;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] next_digit(input logic [2:0] d);
        return (d == 3'(HR_T)) ? 3'(SEC_U) : d + 3'd1;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] digit_strobe(input logic [2:0] d);
        return NUM_DIGITS'(1) << d;
    endfunction

endpackage

// File: rtl/btn_rise_det.sv
// Rising-edge detector for one debounced button level.
// Rise is combinational from the live level vs. a history flop that resets high.
module btn_rise_det (
    input  logic clk_in,
    input  logic resetn,
    input  logic btn_i,
    output logic rise_o
);

    logic btn_q;
    logic btn_d;

    always_comb btn_d = btn_i;

    // History resets to 1 so a button held through reset never produces an edge.
    always_ff @(posedge clk_in) begin
        if (!resetn) btn_q <= 1'b1;
        else         btn_q <= btn_d;
    end

    assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel sequencer: buttons -> one-hot single-step set strobes, digit select and blink.
// Registered outputs, one cycle from button edge to output; a PULSE is atomic once started.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int PULSE_CYCLES  = 101,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000,
    parameter int IDLE_TIMEOUT  = 1_000_000_000,
    parameter int BLINK_HALF    = 25_000_000
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic [5:0] set_o,
    output logic       setting_o,
    output logic [2:0] digit_o,
    output logic       blink_o
);

    localparam int CTR_SPAN = (PULSE_CYCLES > REPEAT_DELAY)
                            ? ((PULSE_CYCLES > REPEAT_PERIOD) ? PULSE_CYCLES : REPEAT_PERIOD)
                            : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CTR_W   = cnt_w(CTR_SPAN);
    localparam int IDLE_W  = cnt_w(IDLE_TIMEOUT);
    localparam int BLINK_W = cnt_w(BLINK_HALF);

    localparam logic [CTR_W-1:0]   PULSE_LOAD  = CTR_W'(PULSE_CYCLES - 1);
    localparam logic [CTR_W-1:0]   DELAY_LOAD  = CTR_W'(REPEAT_DELAY - 1);
    localparam logic [CTR_W-1:0]   PERIOD_LOAD = CTR_W'(REPEAT_PERIOD - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);

    logic mode_rise, next_rise, inc_rise;

    btn_rise_det u_mode (.clk_in(clk_in), .resetn(resetn), .btn_i(btn_mode), .rise_o(mode_rise));
    btn_rise_det u_next (.clk_in(clk_in), .resetn(resetn), .btn_i(btn_next), .rise_o(next_rise));
    btn_rise_det u_inc  (.clk_in(clk_in), .resetn(resetn), .btn_i(btn_inc),  .rise_o(inc_rise));

    state_t               state_q, state_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [BLINK_W-1:0]   blink_ctr_q, blink_ctr_d;
    logic                 blink_q, blink_d;
    logic                 rep_q, rep_d;
    logic [2:0]           digit_q, digit_d;
    logic [5:0]           set_q, set_d;
    logic                 setting_q, setting_d;

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        idle_d      = '0;
        blink_ctr_d = blink_ctr_q;
        blink_d     = blink_q;
        rep_d       = rep_q;
        digit_d     = digit_q;

        case (state_q)
            RUN: begin
                rep_d = 1'b0;
                if (mode_rise) begin
                    state_d     = SET_IDLE;
                    digit_d     = 3'(SEC_U);
                    blink_d     = 1'b1;
                    blink_ctr_d = '0;
                end
            end
            SET_IDLE: begin
                rep_d = 1'b0;
                if (mode_rise) begin
                    state_d = RUN;
                end else if (inc_rise) begin
                    state_d = PULSE;
                    ctr_d   = PULSE_LOAD;
                end else if (next_rise) begin
                    digit_d = next_digit(digit_q);
                end else if (idle_q == IDLE_LAST) begin
                    state_d = RUN;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            PULSE: begin
                // mode/next edges are deliberately dropped here so a step is never truncated.
                if (ctr_q != '0) begin
                    ctr_d = ctr_q - 1'b1;
                end else if (btn_inc) begin
                    state_d = HOLD;
                    ctr_d   = rep_q ? PERIOD_LOAD : DELAY_LOAD;
                end else begin
                    state_d = SET_IDLE;
                end
            end
            HOLD: begin
                if (mode_rise) begin
                    state_d = RUN;
                end else if (!btn_inc) begin
                    state_d = SET_IDLE;
                end else if (ctr_q == '0) begin
                    state_d = PULSE;
                    ctr_d   = PULSE_LOAD;
                    rep_d   = 1'b1;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (state_q != RUN) begin
            if (blink_ctr_q == BLINK_LAST) begin
                blink_ctr_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_ctr_d = blink_ctr_q + 1'b1;
            end
        end
        if (state_d == RUN) begin
            blink_d     = 1'b0;
            blink_ctr_d = '0;
        end

        set_d     = (state_d == PULSE) ? digit_strobe(digit_d) : 6'd0;
        setting_d = (state_d != RUN);
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state_q     <= RUN;
            ctr_q       <= '0;
            idle_q      <= '0;
            blink_ctr_q <= '0;
            blink_q     <= 1'b0;
            rep_q       <= 1'b0;
            digit_q     <= '0;
            set_q       <= '0;
            setting_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            idle_q      <= idle_d;
            blink_ctr_q <= blink_ctr_d;
            blink_q     <= blink_d;
            rep_q       <= rep_d;
            digit_q     <= digit_d;
            set_q       <= set_d;
            setting_q   <= setting_d;
        end
    end

    assign set_o     = set_q;
    assign setting_o = setting_q;
    assign digit_o   = digit_q;
    assign blink_o   = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed vector table, hand sequences and random buttons,
// all cross-checked every cycle against a time-stamp based reference model.
module tb_time_set_controller;

    localparam int P   = 4;
    localparam int DEL = 20;
    localparam int PER = 8;
    localparam int IDL = 50;
    localparam int BH  = 5;

    logic       clk_in   = 1'b0;
    logic       resetn   = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [5:0] set_o;
    logic       setting_o;
    logic [2:0] digit_o;
    logic       blink_o;

    int n_cmp  = 0;
    int n_fail = 0;

    time_set_controller #(
        .PULSE_CYCLES(P), .REPEAT_DELAY(DEL), .REPEAT_PERIOD(PER),
        .IDLE_TIMEOUT(IDL), .BLINK_HALF(BH)
    ) dut (
        .clk_in(clk_in), .resetn(resetn),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .set_o(set_o), .setting_o(setting_o), .digit_o(digit_o), .blink_o(blink_o)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, t);
        end
    endtask

    // Reference model: phases plus absolute edge time stamps.
    int  t = 0;
    bit  m_set, m_rep;
    int  m_phase;          // 0 idle, 1 stepping, 2 waiting to repeat
    int  m_digit, m_mark, m_set_since;
    bit  pm = 1, pn = 1, pi = 1;
    int  e_set, e_setting, e_digit, e_blink;

    task automatic model_step();
        bit mr, nr, ir;
        t++;
        if (!resetn) begin
            m_set = 0; m_phase = 0; m_digit = 0; m_rep = 0;
            pm = 1; pn = 1; pi = 1;
        end else begin
            mr = btn_mode & !pm; nr = btn_next & !pn; ir = btn_inc & !pi;
            pm = btn_mode; pn = btn_next; pi = btn_inc;
            if (!m_set) begin
                if (mr) begin
                    m_set = 1; m_phase = 0; m_digit = 0; m_mark = t; m_set_since = t;
                end
            end else begin
                case (m_phase)
                    0: if (mr) m_set = 0;
                       else if (ir) begin m_phase = 1; m_mark = t; m_rep = 0; end
                       else if (nr) begin m_digit = (m_digit + 1) % 6; m_mark = t; end
                       else if (t - m_mark >= IDL) m_set = 0;
                    1: if (t - m_mark == P) begin
                           if (btn_inc) begin m_phase = 2; m_mark = t + (m_rep ? PER : DEL); end
                           else begin m_phase = 0; m_mark = t; end
                       end
                    default: if (mr) m_set = 0;
                       else if (!btn_inc) begin m_phase = 0; m_mark = t; m_rep = 0; end
                       else if (t == m_mark) begin m_phase = 1; m_mark = t; m_rep = 1; end
                endcase
                if (!m_set) begin m_phase = 0; m_rep = 0; end
            end
        end
        e_setting = m_set;
        e_set     = (m_set && m_phase == 1) ? (1 << m_digit) : 0;
        e_digit   = m_digit;
        e_blink   = m_set ? ((((t - m_set_since) / BH) % 2) == 0) : 0;
    endtask

    task automatic tick(input string tag);
        @(posedge clk_in);
        model_step();
        #1;
        chk({tag, "/m_set"},     32'(set_o),     32'(e_set));
        chk({tag, "/m_setting"}, 32'(setting_o), 32'(e_setting));
        chk({tag, "/m_digit"},   32'(digit_o),   32'(e_digit));
        chk({tag, "/m_blink"},   32'(blink_o),   32'(e_blink));
    endtask

    task automatic drive(input bit m, input bit n, input bit i);
        btn_mode = m; btn_next = n; btn_inc = i;
    endtask

    always @(negedge clk_in) begin
        if (t > 0) chk("onehot0", 32'($onehot0(set_o)), 32'd1);
    end

    typedef struct {
        bit m, n, i;
        logic [5:0] set;
        logic setting;
        logic [2:0] digit;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit m, input bit n, input bit i,
                       input logic [5:0] s, input logic st, input logic [2:0] d);
        vec_t v;
        v.m = m; v.n = n; v.i = i; v.set = s; v.setting = st; v.digit = d;
        vecs.push_back(v);
    endtask

    function automatic bit in_pulse_win(input int k);
        return (k < 4) || (k >= 24 && k < 28) || (k >= 36 && k < 40) || (k >= 48 && k < 52);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rm, rn, ri;
        int ip;

        // Button held through reset must not open SET mode.
        resetn = 1'b0; drive(1, 0, 0);
        repeat (3) tick("rst");
        chk("rst_set", 32'(set_o), 0);
        chk("rst_setting", 32'(setting_o), 0);
        chk("rst_digit", 32'(digit_o), 0);
        chk("rst_blink", 32'(blink_o), 0);
        resetn = 1'b1;
        repeat (3) tick("t1_hold");
        chk("t1_no_entry", 32'(setting_o), 0);
        drive(0, 0, 0); tick("t1_fall");
        chk("t1_fall_run", 32'(setting_o), 0);
        drive(1, 0, 0); tick("t1_rise");
        chk("t1_entry", 32'(setting_o), 1);
        chk("t1_blink_start", 32'(blink_o), 1);
        resetn = 1'b0; drive(0, 0, 0); tick("t1_rst");
        resetn = 1'b1; tick("t1_idle");

        // Directed table: next x2 then single step on digit 2; full digit wrap; priority.
        add(1,0,0, 6'd0,1,3'd0); add(0,0,0, 6'd0,1,3'd0);
        add(0,1,0, 6'd0,1,3'd1); add(0,0,0, 6'd0,1,3'd1);
        add(0,1,0, 6'd0,1,3'd2); add(0,0,0, 6'd0,1,3'd2);
        add(0,0,1, 6'b000100,1,3'd2); add(0,0,0, 6'b000100,1,3'd2);
        add(0,0,0, 6'b000100,1,3'd2); add(0,0,0, 6'b000100,1,3'd2);
        add(0,0,0, 6'd0,1,3'd2); add(0,0,0, 6'd0,1,3'd2);
        add(1,0,0, 6'd0,0,3'd2); add(0,0,0, 6'd0,0,3'd2);
        add(1,0,0, 6'd0,1,3'd0); add(0,0,0, 6'd0,1,3'd0);
        for (int d = 1; d <= 6; d++) begin
            add(0,1,0, 6'd0,1,3'(d % 6)); add(0,0,0, 6'd0,1,3'(d % 6));
        end
        add(1,1,1, 6'd0,0,3'd0); add(0,0,0, 6'd0,0,3'd0); add(0,0,0, 6'd0,0,3'd0);
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].m, vecs[k].n, vecs[k].i);
            tick("vec");
            chk($sformatf("vec%0d_set", k), 32'(set_o), 32'(vecs[k].set));
            chk($sformatf("vec%0d_setting", k), 32'(setting_o), 32'(vecs[k].setting));
            chk($sformatf("vec%0d_digit", k), 32'(digit_o), 32'(vecs[k].digit));
        end

        // Auto-repeat on digit 5.
        drive(1, 0, 0); tick("t4_enter"); drive(0, 0, 0); tick("t4_enter");
        repeat (5) begin
            drive(0, 1, 0); tick("t4_next"); drive(0, 0, 0); tick("t4_next");
        end
        chk("t4_digit5", 32'(digit_o), 5);
        for (int k = 0; k < 60; k++) begin
            drive(0, 0, 1); tick("t4_hold");
            chk($sformatf("t4_rep_k%0d", k), 32'(set_o), in_pulse_win(k) ? 32'd32 : 32'd0);
        end
        drive(0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick("t4_rel");
            chk($sformatf("t4_rel_set%0d", k), 32'(set_o), 0);
            chk($sformatf("t4_rel_setting%0d", k), 32'(setting_o), 1);
        end

        // mode/next during a step are ignored; then idle timeout.
        drive(0, 0, 1); tick("t5_start");
        drive(1, 1, 1); tick("t5_ign");
        chk("t5_ign_set", 32'(set_o), 32);
        drive(0, 0, 0); tick("t5_p"); tick("t5_p");
        chk("t5_still_set", 32'(set_o), 32);
        tick("t5_end");
        chk("t5_end_set", 32'(set_o), 0);
        chk("t5_end_setting", 32'(setting_o), 1);
        chk("t5_digit_kept", 32'(digit_o), 5);
        for (int j = 1; j <= 50; j++) begin
            tick("t5_idle");
            chk($sformatf("t5_idle%0d", j), 32'(setting_o), (j < 50) ? 32'd1 : 32'd0);
        end
        chk("t5_blink_run", 32'(blink_o), 0);

        // Reset during a step.
        drive(1, 0, 0); tick("t6"); drive(0, 0, 0); tick("t6");
        drive(0, 1, 0); tick("t6"); drive(0, 0, 0); tick("t6");
        drive(0, 0, 1); tick("t6_p");
        chk("t6_pulse", 32'(set_o), 2);
        tick("t6_p");
        resetn = 1'b0; tick("t6_rst");
        chk("t6_set0", 32'(set_o), 0);
        chk("t6_setting0", 32'(setting_o), 0);
        chk("t6_digit0", 32'(digit_o), 0);
        resetn = 1'b1; drive(0, 0, 0); tick("t6_rel");

        // Random buttons against the model.
        for (int k = 0; k < 3000; k++) begin
            ip = (k < 1500) ? 11 : 59;
            rm = btn_mode ^ ($urandom_range(0, 39) == 0);
            rn = btn_next ^ ($urandom_range(0, 7) == 0);
            ri = btn_inc  ^ ($urandom_range(0, ip) == 0);
            resetn = ($urandom_range(0, 499) != 0);
            drive(rm, rn, ri);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
